// File: rtl/flex_down_counter.sv
// Loadable down-counter with terminal-count pulse.
// Runs one-shot or auto-reload, restarts on load.
module flex_down_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            count_enable,
  input  logic            auto_reload,
  output logic [SIZE-1:0] count_out,
  output logic            busy,
  output logic            done,
  output logic            zero_flag
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [SIZE-1:0] reload_q, reload_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && count_enable) begin
      // 0 is only reached through the terminal edge, so no wrap
      if (count_q != SIZE'(1)) begin
        count_d = count_q - SIZE'(1);
      end else if (auto_reload) begin
        count_d = reload_q;
        done_d  = 1'b1;
      end else begin
        count_d = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  assign count_out = count_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign zero_flag = (count_q == '0);

endmodule

// File: tb/tb_flex_down_counter.sv
// Self-checking bench for flex_down_counter:
// per-cycle model compare plus directed literals.
module tb_flex_down_counter;
  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            n_rst = 1'b1;
  logic            clear = 1'b0;
  logic            load = 1'b0;
  logic [SIZE-1:0] load_val = '0;
  logic            count_enable = 1'b0;
  logic            auto_reload = 1'b0;
  logic [SIZE-1:0] count_out;
  logic            busy, done, zero_flag;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_cnt = 0;
  int m_rel = 0;
  bit m_run = 1'b0;
  bit m_done = 1'b0;

  flex_down_counter #(.SIZE(SIZE)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .load(load), .load_val(load_val),
    .count_enable(count_enable),
    .auto_reload(auto_reload),
    .count_out(count_out), .busy(busy),
    .done(done), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  // Reference behaviour in plain integers.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_cnt <= 0; m_rel <= 0;
      m_run <= 0; m_done <= 0;
    end else begin
      m_done <= 0;
      if (clear) begin
        m_cnt <= 0; m_run <= 0;
      end else if (load) begin
        m_cnt <= int'(load_val);
        m_rel <= int'(load_val);
        m_run <= (load_val != 0);
      end else if (m_run && count_enable) begin
        if (m_cnt > 1) m_cnt <= m_cnt - 1;
        else begin
          m_done <= 1;
          m_cnt <= auto_reload ? m_rel : 0;
          m_run <= auto_reload;
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.count", 32'(count_out), 32'(m_cnt));
      chk("m.busy", 32'(busy), 32'(m_run));
      chk("m.done", 32'(done), 32'(m_done));
      chk("m.zero", 32'(zero_flag), 32'(m_cnt == 0));
    end
  end

  task automatic tick(input logic cl, input logic ld,
                      input int lv, input logic en,
                      input logic ar);
    clear = cl; load = ld; load_val = SIZE'(lv);
    count_enable = en; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int c,
                     input logic b, input logic d);
    chk({nm, ".cnt"}, 32'(count_out), 32'(c));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    chk({nm, ".done"}, 32'(done), 32'(d));
  endtask

  int exp_c [9] = '{2, 1, 1, 3, 2, 2, 1, 3, 3};
  bit exp_d [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
  int n;
  bit seen;

  initial begin
    #1 n_rst = 1'b0;
    chk_en = 1'b1;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 0);
      lit("idle", 0, 0, 0);
      chk("idle.zero", 32'(zero_flag), 32'd1);
    end

    // one-shot 5
    tick(0, 1, 5, 0, 0);
    lit("os.load", 5, 1, 0);
    for (int v = 4; v >= 0; v--) begin
      tick(0, 0, 0, 1, 0);
      lit("os.step", v, v != 0, v == 0);
    end
    tick(0, 0, 0, 1, 0);
    lit("os.after", 0, 0, 0);

    // periodic 3 with gaps
    tick(0, 1, 3, 0, 1);
    lit("per.load", 3, 1, 0);
    for (int i = 0; i < 9; i++) begin
      tick(0, 0, 0, ((i + 1) % 3) != 0, 1);
      lit("per.step", exp_c[i], 1, exp_d[i]);
    end

    // reload value 1
    tick(0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 1);
      lit("one", 1, 1, 1);
    end

    // load 0
    tick(0, 1, 0, 1, 1);
    lit("zero.load", 0, 0, 0);
    tick(0, 0, 0, 1, 1);
    lit("zero.en", 0, 0, 0);

    // load 15: exactly 15 enabled cycles
    tick(0, 1, 15, 0, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick(0, 0, 0, 1, 0);
      n++;
      seen = done;
    end
    chk("max.len", 32'(n), 32'd15);

    // load collides with terminal count
    tick(0, 1, 2, 0, 0);
    tick(0, 0, 0, 1, 0);
    lit("ld1.pre", 1, 1, 0);
    tick(0, 1, 4, 1, 0);
    lit("ld1", 4, 1, 0);

    // clear + load collide with terminal count
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
    lit("clr.pre", 1, 1, 0);
    tick(1, 1, 7, 1, 1);
    lit("clr", 0, 0, 0);
    tick(0, 0, 0, 1, 1);
    lit("clr.after", 0, 0, 0);

    // auto_reload sampled only at terminal edge
    tick(0, 1, 2, 0, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 0);
    lit("ar.late", 0, 0, 1);

    // async reset mid-countdown
    tick(0, 1, 9, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0);
    lit("rst.pre", 5, 1, 0);
    #2 n_rst = 1'b0;
    #1;
    lit("rst.now", 0, 0, 0);
    chk("rst.zero", 32'(zero_flag), 32'd1);
    n_rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 1, 0);
      seen = seen | done;
    end
    chk("rst.nodone", 32'(seen), 32'd0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
